// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM state type and op-decoding helpers for the multiply/divide unit
package mdu_pkg;
    localparam int MDU_XLEN    = 64;
    localparam int MDUOP_WIDTH = 4;
    localparam logic [MDUOP_WIDTH-1:0] MDU_MUL   = 4'd0;
    localparam logic [MDUOP_WIDTH-1:0] MDU_MULW  = 4'd1;
    localparam logic [MDUOP_WIDTH-1:0] MDU_DIV   = 4'd2;
    localparam logic [MDUOP_WIDTH-1:0] MDU_DIVU  = 4'd3;
    localparam logic [MDUOP_WIDTH-1:0] MDU_REM   = 4'd4;
    localparam logic [MDUOP_WIDTH-1:0] MDU_REMU  = 4'd5;
    localparam logic [MDUOP_WIDTH-1:0] MDU_DIVW  = 4'd6;
    localparam logic [MDUOP_WIDTH-1:0] MDU_DIVUW = 4'd7;
    localparam logic [MDUOP_WIDTH-1:0] MDU_REMW  = 4'd8;
    localparam logic [MDUOP_WIDTH-1:0] MDU_REMUW = 4'd9;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;
    function automatic logic op_known(input logic [MDUOP_WIDTH-1:0] op);
        return op inside {MDU_MUL, MDU_MULW, MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU,
                          MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
    endfunction
    function automatic logic op_div(input logic [MDUOP_WIDTH-1:0] op);
        return op_known(op) && op != MDU_MUL && op != MDU_MULW;
    endfunction
    function automatic logic op_w(input logic [MDUOP_WIDTH-1:0] op);
        return op inside {MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
    endfunction
    function automatic logic op_rem(input logic [MDUOP_WIDTH-1:0] op);
        return op inside {MDU_REM, MDU_REMU, MDU_REMW, MDU_REMUW};
    endfunction
    function automatic logic op_signed(input logic [MDUOP_WIDTH-1:0] op);
        return op inside {MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW};
    endfunction
    function automatic logic [MDU_XLEN-1:0] sext32(input logic [MDU_XLEN-1:0] x, input logic w);
        return w ? {{32{x[31]}}, x[31:0]} : x;
    endfunction
endpackage

// File: rtl/mdu_div.sv
// mdu_div: one restoring-division step (shift in next dividend bit, subtract if it fits)
// Ports:
//   i_rem  partial remainder          o_rem  remainder after this step
//   i_quo  dividend/quotient shifter  o_quo  shifter with the new quotient bit in bit 0
//   i_dvs  divisor magnitude
module mdu_div
    import mdu_pkg::*;
(
    input  logic [MDU_XLEN-1:0] i_rem,
    input  logic [MDU_XLEN-1:0] i_quo,
    input  logic [MDU_XLEN-1:0] i_dvs,
    output logic [MDU_XLEN-1:0] o_rem,
    output logic [MDU_XLEN-1:0] o_quo
);
    logic [MDU_XLEN:0] w_sh;
    logic [MDU_XLEN:0] w_diff;
    // the shifted remainder needs one extra bit; a borrow out of it means the divisor did not fit
    assign w_sh   = {i_rem, i_quo[MDU_XLEN-1]};
    assign w_diff = w_sh - {1'b0, i_dvs};
    assign o_rem  = w_diff[MDU_XLEN] ? w_sh[MDU_XLEN-1:0] : w_diff[MDU_XLEN-1:0];
    assign o_quo  = {i_quo[MDU_XLEN-2:0], ~w_diff[MDU_XLEN]};
endmodule

// File: rtl/mdu.sv
// mdu: iterative RV64M multiply/divide unit returning one result on data/data_ok
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_valid    request; accepted when in_ready is high and flush is low
//   in_ready    high only while IDLE
//   A, B        rs1 / rs2 operands, latched at accept
//   MDUop       operation code (MDU_* in mdu_pkg)
//   flush       abandons the in-flight op; blocks acceptance while IDLE
//   data        registered result, held until the next DONE
//   data_ok     one-cycle result pulse
module mdu
    import mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        A,
    input  logic [XLEN-1:0]        B,
    input  logic [MDUOP_WIDTH-1:0] MDUop,
    input  logic                   flush,
    output logic [XLEN-1:0]        data,
    output logic                   data_ok
);
    localparam logic [XLEN-1:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [XLEN-1:0] MIN32 = 64'hFFFF_FFFF_8000_0000;
    mdu_state_t             r_state, w_next;
    logic [MDUOP_WIDTH-1:0] r_op;
    logic [XLEN-1:0]        r_x, r_y, r_z, r_data;
    logic                   r_nq, r_nr;
    logic [5:0]             r_cnt;
    logic                   w_acc, w_w, w_sg, w_div, w_zero, w_ovf, w_spec;
    logic [XLEN-1:0]        w_ea, w_eb, w_ma, w_mb, w_spec_res;
    logic [XLEN-1:0]        w_q, w_r, w_nx, w_ny, w_nz, w_raw, w_res;
    assign in_ready = r_state == IDLE;
    assign data_ok  = (r_state == DONE) && !flush;
    assign data     = r_data;
    assign w_acc    = in_valid && in_ready && !flush;
    // W operands are widened to 64 bits up front so one datapath and one zero/overflow test serve both widths
    always_comb begin
        w_w        = op_w(MDUop);
        w_sg       = op_signed(MDUop);
        w_div      = op_div(MDUop);
        w_ea       = w_w ? {{32{w_sg & A[31]}}, A[31:0]} : A;
        w_eb       = w_w ? {{32{w_sg & B[31]}}, B[31:0]} : B;
        w_ma       = (w_sg && w_ea[XLEN-1]) ? -w_ea : w_ea;
        w_mb       = (w_sg && w_eb[XLEN-1]) ? -w_eb : w_eb;
        w_zero     = w_eb == '0;
        w_ovf      = w_sg && (w_ea == (w_w ? MIN32 : MIN64)) && (&w_eb);
        w_spec     = !op_known(MDUop) || (w_div && (w_zero || w_ovf));
        w_spec_res = !op_known(MDUop) ? '0 :
                     w_zero ? (op_rem(MDUop) ? sext32(w_ea, w_w) : '1) :
                     (op_rem(MDUop) ? '0 : sext32(w_ea, w_w));
    end
    mdu_div u_div (
        .i_rem (r_z),
        .i_quo (r_x),
        .i_dvs (r_y),
        .o_rem (w_r),
        .o_quo (w_q)
    );
    // divide: r_x = dividend/quotient shifter, r_y = divisor, r_z = remainder
    // multiply: r_x = shifted multiplicand, r_y = multiplier, r_z = accumulator
    // the result is formed from the next-step values so the last iteration and DONE share one edge
    always_comb begin
        w_nx  = op_div(r_op) ? w_q : r_x << 1;
        w_ny  = op_div(r_op) ? r_y : r_y >> 1;
        w_nz  = op_div(r_op) ? w_r : r_z + (r_y[0] ? r_x : '0);
        w_raw = !op_div(r_op) ? w_nz :
                op_rem(r_op) ? (r_nr ? -w_nz : w_nz) : (r_nq ? -w_nx : w_nx);
        w_res = sext32(w_raw, op_w(r_op));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_nq   <= 1'b0;
            r_nr   <= 1'b0;
            r_cnt  <= '0;
            r_data <= '0;
        end else if (w_acc) begin
            r_op  <= MDUop;
            r_x   <= w_div ? (w_w ? w_ma << 32 : w_ma) : A;
            r_y   <= w_div ? w_mb : B;
            r_z   <= '0;
            r_nq  <= w_sg && (w_ea[XLEN-1] ^ w_eb[XLEN-1]);
            r_nr  <= w_sg && w_ea[XLEN-1];
            r_cnt <= w_w ? 6'd31 : 6'd63;
            if (w_spec) r_data <= w_spec_res;
        end else if (r_state == BUSY && !flush) begin
            r_x <= w_nx;
            r_y <= w_ny;
            r_z <= w_nz;
            if (r_cnt == '0) r_data <= w_res;
            else r_cnt <= r_cnt - 6'd1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_acc ? (w_spec ? DONE : BUSY) : IDLE;
            BUSY:    w_next = flush ? IDLE : (r_cnt == '0 ? DONE : BUSY);
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized self-checking bench for mdu against a behavioural reference model
module tb_mdu;
    import mdu_pkg::*;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0;
    logic        in_ready, data_ok;
    logic [63:0] A = '0, B = '0, data;
    logic [3:0]  MDUop = '0;
    int          cyc = 0, checks = 0, errors = 0;
    bit          pend = 0;
    int          acc = 0, due = 0;
    logic [63:0] exp_data = '0, hold = '0;
    mdu #(.XLEN(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .MDUop    (MDUop),
        .flush    (flush),
        .data     (data),
        .data_ok  (data_ok)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask
    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction
    function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [31:0]        a32, b32, u32;
        logic signed [31:0] s32;
        logic signed [63:0] s64;
        logic               z64, z32, o64, o32;
        a32 = a[31:0];
        b32 = b[31:0];
        z64 = b == 64'd0;
        z32 = b32 == 32'd0;
        o64 = a == 64'h8000_0000_0000_0000 && b == '1;
        o32 = a32 == 32'h8000_0000 && b32 == '1;
        case (op)
            4'd0: return a * b;
            4'd1: begin u32 = a32 * b32; return sx(u32); end
            4'd2: begin
                if (z64) return '1;
                if (o64) return a;
                s64 = $signed(a) / $signed(b);
                return s64;
            end
            4'd3: return z64 ? '1 : a / b;
            4'd4: begin
                if (z64) return a;
                if (o64) return 64'd0;
                s64 = $signed(a) % $signed(b);
                return s64;
            end
            4'd5: return z64 ? a : a % b;
            4'd6: begin
                if (z32) return '1;
                if (o32) return sx(a32);
                s32 = $signed(a32) / $signed(b32);
                return sx(s32);
            end
            4'd7: return z32 ? '1 : sx(a32 / b32);
            4'd8: begin
                if (z32) return sx(a32);
                if (o32) return 64'd0;
                s32 = $signed(a32) % $signed(b32);
                return sx(s32);
            end
            4'd9: return z32 ? sx(a32) : sx(a32 % b32);
            default: return 64'd0;
        endcase
    endfunction
    function automatic int lat_of(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        bit w, z, o;
        if (op > 4'd9) return 1;
        w = op == 4'd1 || op >= 4'd6;
        if (op >= 4'd2) begin
            z = w ? b[31:0] == 32'd0 : b == 64'd0;
            o = (op == 4'd2 || op == 4'd4 || op == 4'd6 || op == 4'd8) &&
                (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1) : (a == 64'h8000_0000_0000_0000 && b == '1));
            if (z || o) return 1;
        end
        return w ? 33 : 65;
    endfunction
    function automatic logic [63:0] rnd();
        case ($urandom_range(0, 8))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return {$urandom, 32'h8000_0000};
            4: return {$urandom, 32'hFFFF_FFFF};
            5: return 64'($urandom_range(0, 20));
            6: return {32'd0, $urandom};
            7: return {$urandom, 32'd0};
            default: return {$urandom, $urandom};
        endcase
    endfunction
    // the compare process: every cycle, in_ready/data_ok/data against the model's view of the op in flight
    always @(negedge clk) begin
        if (!rst_n) hold = '0;
        else if (pend && cyc == due) hold = exp_data;
        chk("in_ready", {63'd0, in_ready}, {63'd0, !(rst_n && pend && cyc >= acc && cyc <= due)});
        chk("data_ok", {63'd0, data_ok}, {63'd0, rst_n && pend && cyc == due && !flush});
        chk("data", data, hold);
    end
    // called at posedge+1 with the unit idle; fl/rs = cycle after accept at which to flush/reset (0 = never)
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input int fl, input int rs);
        int lat;
        lat = lat_of(op, a, b);
        in_valid = 1'b1;
        MDUop = op;
        A = a;
        B = b;
        exp_data = ref_res(op, a, b);
        acc = cyc + 1;
        due = acc + lat - 1;
        pend = 1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = {$urandom, $urandom};
        B = {$urandom, $urandom};
        MDUop = 4'($urandom);
        while (cyc <= due) begin
            if (rs > 0 && cyc == acc + rs - 1) begin
                in_valid = 1'b0;
                #1 rst_n = 1'b0;
                pend = 0;
                #1;
                chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
                chk("rst_data_ok", {63'd0, data_ok}, 64'd0);
                chk("rst_data", data, 64'd0);
                @(posedge clk); #1;
                @(posedge clk); #1 rst_n = 1'b1;
                return;
            end
            if (fl > 0 && cyc == acc + fl - 1) begin
                in_valid = 1'b0;
                flush = 1'b1;
                @(posedge clk); #1 flush = 1'b0;
                pend = 0;
                return;
            end
            in_valid = $urandom_range(0, 3) == 0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask
    initial begin
        logic [3:0]  op;
        logic [63:0] a, b;
        int          lat, fl;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_data_ok", {63'd0, data_ok}, 64'd0);
        chk("reset_data", data, 64'd0);
        chk("model_mul", ref_res(MDU_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("model_divw", ref_res(MDU_DIVW, 64'h0000_0000_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model_remw", ref_res(MDU_REMW, 64'h0000_0000_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("model_divu0", ref_res(MDU_DIVU, 64'd5, 64'd0), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("model_remu0", ref_res(MDU_REMU, 64'd5, 64'd0), 64'd5);
        chk("model_divovf", ref_res(MDU_DIV, 64'h8000_0000_0000_0000, '1), 64'h8000_0000_0000_0000);
        chk("model_lat64", 64'(lat_of(MDU_MUL, 64'd7, 64'd3)), 64'd65);
        chk("model_latw", 64'(lat_of(MDU_DIVW, 64'd7, 64'd2)), 64'd33);
        chk("model_latsp", 64'(lat_of(MDU_DIVU, 64'd5, 64'd0)), 64'd1);
        issue(MDU_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0);
        chk("t_mul", data, 64'hFFFF_FFFF_FFFF_FFEB);
        issue(MDU_DIVW, 64'h0000_0000_FFFF_FFF9, 64'd2, 0, 0);
        chk("t_divw", data, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(MDU_REMW, 64'h0000_0000_FFFF_FFF9, 64'd2, 0, 0);
        chk("t_remw", data, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(MDU_DIVU, 64'd5, 64'd0, 0, 0);
        chk("t_divu0", data, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(MDU_REMU, 64'd5, 64'd0, 0, 0);
        chk("t_remu0", data, 64'd5);
        issue(MDU_DIV, 64'h8000_0000_0000_0000, '1, 0, 0);
        chk("t_divovf", data, 64'h8000_0000_0000_0000);
        issue(MDU_REM, 64'h8000_0000_0000_0000, '1, 0, 0);
        chk("t_removf", data, 64'd0);
        issue(MDU_DIV, 64'd1000, 64'd7, 20, 0);
        chk("t_flush_ready", {63'd0, in_ready}, 64'd1);
        issue(MDU_MULW, 64'd3, 64'd4, 0, 0);
        chk("t_mulw", data, 64'd12);
        issue(MDU_MUL, 64'd123, 64'd456, 0, 10);
        repeat (3) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        flush = 1'b1;
        MDUop = MDU_DIVU;
        A = 64'd5;
        B = 64'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        issue(4'd12, 64'd9, 64'd9, 0, 0);
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 11));
            if (op >= 4'd10) op = 4'($urandom_range(10, 15));
            a = rnd();
            b = rnd();
            lat = lat_of(op, a, b);
            fl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, lat)) : 0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            issue(op, a, b, fl, 0);
        end
        repeat (3) begin @(posedge clk); #1; end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
